// File: rtl/pac_pkg.sv
// Shared types, legal-word bit positions and helpers for the Pac-Man motion controller.
package pac_pkg;

    typedef enum logic [1:0] {
        DIR_L = 2'd0,
        DIR_R = 2'd1,
        DIR_U = 2'd2,
        DIR_D = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        SETTLE,
        DECIDE,
        MOVE,
        STOP
    } state_t;

    localparam int LGL_L  = 3;
    localparam int LGL_R  = 2;
    localparam int LGL_U  = 1;
    localparam int LGL_D  = 0;
    localparam int GRID_N = 8;

    function automatic logic dir_legal(input logic [3:0] lgl, input dir_t d);
        case (d)
            DIR_L:   return lgl[LGL_L];
            DIR_R:   return lgl[LGL_R];
            DIR_U:   return lgl[LGL_U];
            default: return lgl[LGL_D];
        endcase
    endfunction

    // Button word shares the legal-word bit layout; L wins over R over U over D.
    function automatic dir_t btn_dir(input logic [3:0] b);
        if (b[LGL_L])      return DIR_L;
        else if (b[LGL_R]) return DIR_R;
        else if (b[LGL_U]) return DIR_U;
        else               return DIR_D;
    endfunction

endpackage

// File: rtl/pac_step_timer.sv
// Divides the clock down to a one-cycle pixel-step tick; restart re-phases the divider.
module pac_step_timer #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (restart_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/pac_mover.sv
// Pac-Man motion controller: buffered turn requests, tile-aligned decisions, divided pixel stepping.
// Define PAC_STICKY_TURN_EN to keep an unconsumed turn request alive across tiles.
module pac_mover
    import pac_pkg::*;
#(
    parameter int TILE_PX   = 60,
    parameter int STEP_DIV  = 4,
    parameter int LEGAL_LAT = 1,
    parameter int START_X   = 3,
    parameter int START_Y   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic [3:0] legal,
    output logic [2:0] tile_x,
    output logic [2:0] tile_y,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic [1:0] dir,
    output logic       moving,
    output logic       tile_done
);
    localparam int PX_W = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
    localparam logic [PX_W-1:0] PX_LAST  = PX_W'(TILE_PX - 1);
    localparam logic [1:0]      LAT_LAST = (LEGAL_LAT > 0) ? 2'(LEGAL_LAT - 1) : 2'd0;

    state_t          state_q;
    dir_t            dir_q;
    logic [2:0]      tile_x_q, tile_y_q;
    logic [9:0]      xpos_q, ypos_q;
    logic            moving_q, tile_done_q;
    logic [PX_W-1:0] px_cnt_q;
    logic [1:0]      lat_cnt_q;
    logic            q_vld_q, q_vld_d;
    dir_t            q_dir_q, q_dir_d;

    logic decide_now, take_q, start, arrive, tick;
    dir_t new_dir;

    pac_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .restart_i (start),
        .en_i      (state_q == MOVE),
        .tick_o    (tick)
    );

    always_comb begin
        // With zero lookup latency the settle cycle doubles as the decision cycle.
        decide_now = (state_q == DECIDE) || ((state_q == SETTLE) && (LEGAL_LAT == 0));
        take_q     = (decide_now || (state_q == STOP)) && q_vld_q && dir_legal(legal, q_dir_q);
        start      = take_q || (decide_now && dir_legal(legal, dir_q));
        new_dir    = take_q ? q_dir_q : dir_q;
        arrive     = tick && (px_cnt_q == PX_LAST);

        q_vld_d = q_vld_q;
        q_dir_d = q_dir_q;
`ifdef PAC_STICKY_TURN_EN
        if (take_q) q_vld_d = 1'b0;
`else
        // Leaving a tile without the request taken means it was meant for this tile only.
        if (start) q_vld_d = 1'b0;
`endif
        if (|btn) begin
            q_vld_d = 1'b1;
            q_dir_d = btn_dir(btn);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SETTLE;
            dir_q       <= DIR_L;
            tile_x_q    <= 3'(START_X);
            tile_y_q    <= 3'(START_Y);
            xpos_q      <= 10'(START_X * TILE_PX);
            ypos_q      <= 10'(START_Y * TILE_PX);
            moving_q    <= 1'b0;
            tile_done_q <= 1'b0;
            px_cnt_q    <= '0;
            lat_cnt_q   <= '0;
            q_vld_q     <= 1'b0;
            q_dir_q     <= DIR_L;
        end else begin
            q_vld_q     <= q_vld_d;
            q_dir_q     <= q_dir_d;
            tile_done_q <= 1'b0;
            case (state_q)
                MOVE: begin
                    if (tick) begin
                        case (dir_q)
                            DIR_L:   xpos_q <= xpos_q - 10'd1;
                            DIR_R:   xpos_q <= xpos_q + 10'd1;
                            DIR_U:   ypos_q <= ypos_q - 10'd1;
                            default: ypos_q <= ypos_q + 10'd1;
                        endcase
                        if (arrive) begin
                            case (dir_q)
                                DIR_L:   tile_x_q <= tile_x_q - 3'd1;
                                DIR_R:   tile_x_q <= tile_x_q + 3'd1;
                                DIR_U:   tile_y_q <= tile_y_q - 3'd1;
                                default: tile_y_q <= tile_y_q + 3'd1;
                            endcase
                            px_cnt_q    <= '0;
                            lat_cnt_q   <= '0;
                            tile_done_q <= 1'b1;
                            moving_q    <= 1'b0;
                            state_q     <= SETTLE;
                        end else begin
                            px_cnt_q <= px_cnt_q + PX_W'(1);
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_q  <= MOVE;
                        dir_q    <= new_dir;
                        moving_q <= 1'b1;
                    end else if (decide_now) begin
                        state_q <= STOP;
                    end else if (state_q == SETTLE) begin
                        if (lat_cnt_q == LAT_LAST) state_q <= DECIDE;
                        else                       lat_cnt_q <= lat_cnt_q + 2'd1;
                    end
                end
            endcase
        end
    end

    assign tile_x    = tile_x_q;
    assign tile_y    = tile_y_q;
    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign dir       = dir_q;
    assign moving    = moving_q;
    assign tile_done = tile_done_q;

endmodule

// File: tb/tb_pac_mover.sv
// Bench for pac_mover: directed maze scenarios plus a random maze walk against a tile-level model.
`timescale 1ns/1ps
module tb_pac_mover;
    localparam int TILE_PX   = 60;
    localparam int STEP_DIV  = 2;
    localparam int LEGAL_LAT = 1;
    localparam int TILE_CYC  = TILE_PX * STEP_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'd0;
    logic [3:0] legal = 4'd0;
    logic [2:0] tile_x, tile_y;
    logic [9:0] xpos, ypos;
    logic [1:0] dir;
    logic       moving, tile_done;

    logic [3:0] lgl_tab [8][8];
    int total = 0;
    int bad   = 0;

    pac_mover #(
        .TILE_PX(TILE_PX), .STEP_DIV(STEP_DIV), .LEGAL_LAT(LEGAL_LAT), .START_X(3), .START_Y(3)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .legal(legal),
        .tile_x(tile_x), .tile_y(tile_y), .xpos(xpos), .ypos(ypos),
        .dir(dir), .moving(moving), .tile_done(tile_done)
    );

    always #5 clk = ~clk;

    // Legal-move lookup with one cycle of latency.
    always @(posedge clk) legal <= lgl_tab[tile_y][tile_x];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = 4'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        tick();
        btn = 4'd0;
    endtask

    task automatic wait_tile(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!tile_done && n < 400);
        check({tag, "_cycles"}, n, exp_n);
    endtask

    function automatic int prio(input logic [3:0] b);
        if (b[3])      return 0;
        else if (b[2]) return 1;
        else if (b[1]) return 2;
        else           return 3;
    endfunction

    function automatic bit can_go(input int x, input int y, input int d);
        logic [3:0] w;
        w = lgl_tab[y][x];
        return w[3-d];
    endfunction

    initial begin
        logic [3:0] w, b;
        int mx, my, mdir, qd, r, n;
        bit qv, go;

        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                lgl_tab[y][x] = 4'b0000;
        lgl_tab[3][3] = 4'b1100;
        lgl_tab[3][2] = 4'b1100;
        lgl_tab[3][1] = 4'b0111;
        lgl_tab[3][4] = 4'b1000;
        lgl_tab[2][1] = 4'b0001;

        // Reset values
        do_reset();
        check("rst_tx", tile_x, 3);
        check("rst_ty", tile_y, 3);
        check("rst_x", xpos, 180);
        check("rst_y", ypos, 180);
        check("rst_dir", dir, 0);
        check("rst_mov", moving, 0);
        check("rst_done", tile_done, 0);

        // Default heading L is legal at start, so it moves; reset mid-move acts at once
        repeat (40) tick();
        check("mid_mov", moving, 1);
        check("mid_x", xpos, 180 - 19);
        #2 rst = 1'b1;
        #1;
        check("arst_tx", tile_x, 3);
        check("arst_x", xpos, 180);
        check("arst_y", ypos, 180);
        check("arst_dir", dir, 0);
        check("arst_mov", moving, 0);

        // Request R before the first decision
        do_reset();
        press(4'b0100);
        tick();
        check("r_mov", moving, 1);
        check("r_dir", dir, 1);
        wait_tile("r_tile", TILE_CYC);
        check("r_tx", tile_x, 4);
        check("r_x", xpos, 240);
        tick();
        check("r_pulse", tile_done, 0);
        tick();
        check("r_stop", moving, 0);
        check("r_stop_dir", dir, 1);

        // Run L with no request until the dead end at (1,3)
        do_reset();
        wait_tile("l1", TILE_CYC + 2);
        check("l1_tx", tile_x, 2);
        check("l1_x", xpos, 120);
        wait_tile("l2", TILE_CYC + 2);
        check("l2_tx", tile_x, 1);
        tick();
        tick();
        repeat (5) tick();
        check("l2_stop", moving, 0);
        check("l2_dir", dir, 0);
        check("l2_x", xpos, 60);

        // All buttons in STOP: L wins and is illegal; then R is taken
        press(4'b1111);
        repeat (3) tick();
        check("p_stay", moving, 0);
        check("p_dir", dir, 0);
        press(4'b0100);
        tick();
        check("p_mov", moving, 1);
        check("p_dir_r", dir, 1);
        wait_tile("p_tile", TILE_CYC);
        check("p_tx", tile_x, 2);

        // U pressed while leaving (2,3) is taken at (1,3)
        do_reset();
        wait_tile("u_a", TILE_CYC + 2);
        repeat (10) tick();
        press(4'b0010);
        wait_tile("u_b", TILE_CYC + 2 - 11);
        wait_tile("u_c", TILE_CYC + 2);
        check("u_tx", tile_x, 1);
        check("u_ty", tile_y, 2);
        check("u_y", ypos, 120);
        check("u_x", xpos, 60);
        check("u_dir", dir, 2);

        // U pressed while leaving (3,3) is not usable at (2,3)
        do_reset();
        repeat (10) tick();
        press(4'b0010);
        wait_tile("u2_a", TILE_CYC + 2 - 11);
        tick();
        tick();
        check("u2_dir", dir, 0);
        check("u2_mov", moving, 1);
        wait_tile("u2_b", TILE_CYC);
        check("u2_tx", tile_x, 1);
        tick();
        tick();
`ifdef PAC_STICKY_TURN_EN
        check("u2_end_mov", moving, 1);
        check("u2_end_dir", dir, 2);
`else
        check("u2_end_mov", moving, 0);
        check("u2_end_dir", dir, 0);
`endif

        // D mid-tile: no reversal before alignment, illegal at (2,3)
        do_reset();
        repeat (30) tick();
        press(4'b0001);
        wait_tile("d_a", TILE_CYC + 2 - 31);
        check("d_tx", tile_x, 2);
        check("d_x", xpos, 120);
        tick();
        tick();
        check("d_dir", dir, 0);
        check("d_mov", moving, 1);
        wait_tile("d_b", TILE_CYC);
        tick();
        tick();
`ifdef PAC_STICKY_TURN_EN
        check("d_end_dir", dir, 3);
        check("d_end_mov", moving, 1);
`else
        check("d_end_dir", dir, 0);
        check("d_end_mov", moving, 0);
`endif

        // Random maze walk against a tile-level model
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                w = 4'($urandom);
                if (x == 0) w[3] = 1'b0;
                if (x == 7) w[2] = 1'b0;
                if (y == 0) w[1] = 1'b0;
                if (y == 7) w[0] = 1'b0;
                if (w == 4'd0) w = (x > 0) ? 4'b1000 : 4'b0100;
                lgl_tab[y][x] = w;
            end
        mx = 3; my = 3; mdir = 0; qv = 0; qd = 0;
        do_reset();
        for (int it = 0; it < 20; it++) begin
            go = 0;
            if (qv && can_go(mx, my, qd)) begin
                mdir = qd; qv = 0; go = 1;
            end else if (can_go(mx, my, mdir)) begin
                go = 1;
`ifndef PAC_STICKY_TURN_EN
                qv = 0;
`endif
            end
            tick();
            tick();
            check("rnd_go", moving, go);
            check("rnd_dir", dir, mdir);
            for (int a = 0; a < 6 && !go; a++) begin
                if (a < 4) begin
                    b = 4'($urandom_range(1, 15));
                end else begin
                    w = lgl_tab[my][mx];
                    b = w[3] ? 4'b1000 : w[2] ? 4'b0100 : w[1] ? 4'b0010 : 4'b0001;
                end
                press(b);
                tick();
                qv = 1; qd = prio(b);
                if (can_go(mx, my, qd)) begin
                    mdir = qd; qv = 0; go = 1;
                end
                check("rnd_stop_go", moving, go);
                check("rnd_stop_dir", dir, mdir);
            end
            r = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 100)) : 0;
            b = 4'($urandom_range(1, 15));
            n = 0;
            do begin
                n++;
                if (n == r) btn = b;
                tick();
                btn = 4'd0;
            end while (!tile_done && n < 400);
            if (r != 0) begin
                qv = 1; qd = prio(b);
            end
            case (mdir)
                0: mx--;
                1: mx++;
                2: my--;
                default: my++;
            endcase
            check("rnd_cycles", n, TILE_CYC);
            check("rnd_tx", tile_x, mx);
            check("rnd_ty", tile_y, my);
            check("rnd_x", xpos, mx * TILE_PX);
            check("rnd_y", ypos, my * TILE_PX);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
